// File: rtl/noc_sw_alloc_if.sv
// Switch-allocator bundle: SA requests/grants, credit returns,
// registered crossbar controls and credit status for one router.
interface noc_sw_alloc_if #(
  parameter int N_PORTS     = 5,
  parameter int N_VC        = 4,
  parameter int CREDIT_BITS = 4
);
  localparam int PB = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int VB = (N_VC > 1) ? $clog2(N_VC) : 1;
  localparam int NV = N_PORTS * N_VC;

  logic [NV-1:0]             sa_req;
  logic [NV*PB-1:0]          sa_route;
  logic [NV*VB-1:0]          sa_ovid;
  logic [NV-1:0]             sa_tail;
  logic [NV-1:0]             sa_gnt;
  logic [NV-1:0]             credit_ret;
  logic [N_PORTS-1:0]        xbar_vld;
  logic [N_PORTS*PB-1:0]     xbar_sel;
  logic [NV*CREDIT_BITS-1:0] credit_cnt;
  logic                      err_credit_ovf;

  modport master (
    output sa_req, sa_route, sa_ovid, sa_tail, credit_ret,
    input  sa_gnt, xbar_vld, xbar_sel, credit_cnt,
    input  err_credit_ovf
  );

  modport slave (
    input  sa_req, sa_route, sa_ovid, sa_tail, credit_ret,
    output sa_gnt, xbar_vld, xbar_sel, credit_cnt,
    output err_credit_ovf
  );
endinterface

// File: rtl/noc_sw_alloc.sv
// Separable round-robin switch allocator with per-output-VC credits.
// Ports: clk, rst (sync, active-high), sa (noc_sw_alloc_if.slave):
//   sa_req/route/ovid/tail in, sa_gnt out (comb pop strobe),
//   credit_ret in, xbar_vld/xbar_sel out (registered), credit_cnt out,
//   err_credit_ovf out (sticky). SA_PKT_LOCK_EN: wormhole output locks.
module noc_sw_alloc #(
  parameter int N_PORTS     = 5,
  parameter int N_VC        = 4,
  parameter int CREDIT_BITS = 4,
  parameter int CREDIT_MAX  = 8
) (
  input logic          clk,
  input logic          rst,
  noc_sw_alloc_if.slave sa
);
  localparam int PB = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int VB = (N_VC > 1) ? $clog2(N_VC) : 1;
  localparam int NV = N_PORTS * N_VC;

  typedef logic [PB-1:0] port_t;
  typedef logic [VB-1:0] vc_t;
  typedef logic [CREDIT_BITS-1:0] cred_t;

  vc_t                in_ptr_q [N_PORTS];
  port_t              out_ptr_q[N_PORTS];
  cred_t              cred_q   [NV];
  logic [N_PORTS-1:0] xv_q;
  port_t              xs_q     [N_PORTS];
  logic               err_q;

  port_t              rt   [NV];
  vc_t                ov   [NV];
  logic [NV-1:0]      elig;
  logic [N_PORTS-1:0] c_vld;
  vc_t                c_vc [N_PORTS];
  port_t              c_out[N_PORTS];
  logic [N_PORTS-1:0] w_vld;
  port_t              w_port[N_PORTS];
  vc_t                w_vc [N_PORTS];
  logic [NV-1:0]      gnt;
  logic [NV-1:0]      dec;

`ifdef SA_PKT_LOCK_EN
  logic [N_PORTS-1:0] lk_vld;
  port_t              lk_port[N_PORTS];
  vc_t                lk_vc  [N_PORTS];
  logic [N_PORTS-1:0] w_tail;
  logic [NV-1:0]      own;
`else
  logic unused_tail;
  assign unused_tail = ^sa.sa_tail;
`endif

  // Request decode; an out-of-range route is never eligible.
  always_comb begin
    for (int v = 0; v < NV; v++) begin
      rt[v]   = sa.sa_route[v*PB +: PB];
      ov[v]   = sa.sa_ovid[v*VB +: VB];
      elig[v] = 1'b0;
      if (sa.sa_req[v] && int'(rt[v]) < N_PORTS)
        elig[v] = cred_q[int'(rt[v])*N_VC + int'(ov[v])] != '0;
`ifdef SA_PKT_LOCK_EN
      own[v] = 1'b0;
      if (elig[v])
        own[v] = lk_vld[rt[v]] &&
                 lk_port[rt[v]] == port_t'(v / N_VC) &&
                 lk_vc[rt[v]] == vc_t'(v % N_VC);
`endif
    end
  end

  // Stage 1: one candidate VC per input port.
  always_comb begin
    int   idx;
    int   v;
    logic pri;
    idx = 0;
    v   = 0;
    pri = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      c_vld[i] = 1'b0;
      c_vc[i]  = '0;
      c_out[i] = '0;
      pri      = 1'b0;
`ifdef SA_PKT_LOCK_EN
      for (int k = 0; k < N_VC; k++)
        pri = pri | own[i*N_VC + k];
`endif
      for (int k = 0; k < N_VC; k++) begin
        idx = int'(in_ptr_q[i]) + k;
        if (idx >= N_VC) idx = idx - N_VC;
        v = i*N_VC + idx;
`ifdef SA_PKT_LOCK_EN
        if (!c_vld[i] && elig[v] && (!pri || own[v])) begin
`else
        if (!c_vld[i] && elig[v] && !pri) begin
`endif
          c_vld[i] = 1'b1;
          c_vc[i]  = vc_t'(idx);
          c_out[i] = rt[v];
        end
      end
    end
  end

  // Stage 2: one input port per output port.
  always_comb begin
    int   idx;
    logic acc;
    idx = 0;
    acc = 1'b0;
    for (int o = 0; o < N_PORTS; o++) begin
      w_vld[o]  = 1'b0;
      w_port[o] = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = int'(out_ptr_q[o]) + k;
        if (idx >= N_PORTS) idx = idx - N_PORTS;
        acc = c_vld[idx] && int'(c_out[idx]) == o;
`ifdef SA_PKT_LOCK_EN
        acc = acc && (!lk_vld[o] ||
              (lk_port[o] == port_t'(idx) && lk_vc[o] == c_vc[idx]));
`endif
        if (!w_vld[o] && acc) begin
          w_vld[o]  = 1'b1;
          w_port[o] = port_t'(idx);
        end
      end
    end
  end

  always_comb begin
    int wv;
    wv  = 0;
    gnt = '0;
    dec = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      w_vc[o] = c_vc[w_port[o]];
      wv      = int'(w_port[o])*N_VC + int'(w_vc[o]);
`ifdef SA_PKT_LOCK_EN
      w_tail[o] = sa.sa_tail[wv];
`endif
      if (w_vld[o]) begin
        gnt[wv] = 1'b1;
        dec[o*N_VC + int'(ov[wv])] = 1'b1;
      end
    end
  end

  assign sa.sa_gnt = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PORTS; i++) begin
        in_ptr_q[i]  <= '0;
        out_ptr_q[i] <= '0;
        xs_q[i]      <= '0;
      end
      for (int i = 0; i < NV; i++)
        cred_q[i] <= cred_t'(CREDIT_MAX);
      xv_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (w_vld[o]) begin
          in_ptr_q[w_port[o]] <= (w_vc[o] == vc_t'(N_VC-1)) ?
                                 '0 : w_vc[o] + 1'b1;
          out_ptr_q[o] <= (int'(w_port[o]) == N_PORTS-1) ?
                          '0 : w_port[o] + 1'b1;
          xs_q[o] <= w_port[o];
        end
      end
      xv_q <= w_vld;
      for (int i = 0; i < NV; i++) begin
        unique case (1'b1)
          dec[i] && !sa.credit_ret[i]:
            cred_q[i] <= cred_q[i] - 1'b1;
          sa.credit_ret[i] && !dec[i]:
            if (cred_q[i] == cred_t'(CREDIT_MAX)) err_q <= 1'b1;
            else cred_q[i] <= cred_q[i] + 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef SA_PKT_LOCK_EN
  // Non-tail grant on a free output locks it; owner tail frees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_vld <= '0;
      for (int o = 0; o < N_PORTS; o++) begin
        lk_port[o] <= '0;
        lk_vc[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (w_vld[o]) begin
          if (lk_vld[o]) begin
            if (w_tail[o]) lk_vld[o] <= 1'b0;
          end else if (!w_tail[o]) begin
            lk_vld[o]  <= 1'b1;
            lk_port[o] <= w_port[o];
            lk_vc[o]   <= w_vc[o];
          end
        end
      end
    end
  end
`endif

  always_comb begin
    for (int o = 0; o < N_PORTS; o++)
      sa.xbar_sel[o*PB +: PB] = xs_q[o];
    for (int i = 0; i < NV; i++)
      sa.credit_cnt[i*CREDIT_BITS +: CREDIT_BITS] = cred_q[i];
  end

  assign sa.xbar_vld       = xv_q;
  assign sa.err_credit_ovf = err_q;
endmodule
